// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encodings and constants for the IF/MEM shared-port arbiter.
package mem_port_arbiter_pkg;

    localparam int ARB_DATA_W           = 32;
    localparam int ARB_STARVE_LIMIT_DEF = 3;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_BUSY_IF  = 3'd1,
        ARB_BUSY_MEM = 3'd2,
        ARB_RESP_IF  = 3'd3,
        ARB_RESP_MEM = 3'd4
    } arb_state_t;

    function automatic int arb_cnt_w(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// arb_starve_counter: consecutive-MEM-grant counter that lets a waiting IF through.
// Only compiled when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic grant_if,
    input  logic grant_mem,
    input  logic if_req,
    output logic limit_hit
);

    localparam int              CW    = arb_cnt_w(STARVE_LIMIT);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] count;

    // Only MEM grants that overtook a pending fetch count toward the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (grant_if) begin
            count <= '0;
        end else if (grant_mem) begin
            if (!if_req)
                count <= '0;
            else if (count != LIMIT)
                count <= count + 1'b1;
        end
    end

    assign limit_hit = (count == LIMIT);

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stage accesses onto one single-port memory; MEM has priority.
// Define ARB_STARVE_GUARD_EN to let IF through after STARVE_LIMIT back-to-back MEM grants.
//
// state        | meaning
// ARB_IDLE     | no access in flight, grant decision made here
// ARB_BUSY_IF  | fetch access on the RAM port, waiting for ram_ack
// ARB_BUSY_MEM | load/store access on the RAM port, waiting for ram_ack
// ARB_RESP_IF  | if_done pulse
// ARB_RESP_MEM | mem_done pulse
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
)
`endif
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ARB_DATA_W-1:0] if_addr,
    output logic [ARB_DATA_W-1:0] if_rdata,
    output logic                  if_done,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ARB_DATA_W-1:0] mem_addr,
    input  logic [ARB_DATA_W-1:0] mem_wdata,
    output logic [ARB_DATA_W-1:0] mem_rdata,
    output logic                  mem_done,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ARB_DATA_W-1:0] ram_addr,
    output logic [ARB_DATA_W-1:0] ram_wdata,
    input  logic [ARB_DATA_W-1:0] ram_rdata,
    input  logic                  ram_ack,
    output logic                  stall_if,
    output logic                  stall_mem
);

    arb_state_t              state, next_state;
    logic                    mem_any;
    logic                    starve_hit;
    logic                    grant_if, grant_mem;
    logic                    we_q;
    logic [ARB_DATA_W-1:0]   addr_q, wdata_q;

    assign mem_any = mem_rd | mem_wr;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant_if  (grant_if),
        .grant_mem (grant_mem),
        .if_req    (if_req),
        .limit_hit (starve_hit)
    );
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ARB_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (mem_any && !(if_req && starve_hit)) begin
                    grant_mem  = 1'b1;
                    next_state = ARB_BUSY_MEM;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    next_state = ARB_BUSY_IF;
                end
            end
            ARB_BUSY_IF:  if (ram_ack) next_state = ARB_RESP_IF;
            ARB_BUSY_MEM: if (ram_ack) next_state = ARB_RESP_MEM;
            ARB_RESP_IF,
            ARB_RESP_MEM: next_state = ARB_IDLE;
            default:      next_state = ARB_IDLE;
        endcase
    end

    // mem_wr alone decides the direction, so rd+wr together becomes a store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if (grant_mem) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                we_q    <= mem_wr;
            end else if (grant_if) begin
                addr_q  <= if_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end
            if (state == ARB_BUSY_IF && ram_ack)
                if_rdata <= ram_rdata;
            if (state == ARB_BUSY_MEM && ram_ack && !we_q)
                mem_rdata <= ram_rdata;
        end
    end

    assign ram_req   = (state == ARB_BUSY_IF) || (state == ARB_BUSY_MEM);
    assign ram_we    = we_q & ram_req;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_done   = (state == ARB_RESP_IF);
    assign mem_done  = (state == ARB_RESP_MEM);
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_any & ~mem_done;

endmodule
